// File: rtl/io_cfg_bank_ctrl.sv
// Configuration bank write controller: one SETUP / PULSE / HOLD wordline sequence per accepted word.
// Define IO_CFG_PARITY_EN to add the cfg_parity input and the sticky par_err output.
module io_cfg_bank_ctrl #(
  parameter int WL_PULSE = 2,
  parameter int NUM_WL   = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  input  logic              cfg_last,
`ifdef IO_CFG_PARITY_EN
  input  logic              cfg_parity,
  output logic              par_err,
`endif
  output logic [0:7]        bl,
  output logic [0:NUM_WL-1] wl,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [3:0] NUM_WL_L = 4'(NUM_WL);
  localparam logic [3:0] PULSE_LAST = 4'(WL_PULSE - 1);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              last_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              addr_err_reg;
  logic [0:7]        bl_reg;
  logic [0:NUM_WL-1] wl_reg;
  logic [0:NUM_WL-1] sel_reg;
  logic [0:NUM_WL-1] sel_dec;
  logic [0:7]        bl_pat;
  logic              word_bad;
  logic              addr_oor;
  logic              accept;

`ifdef IO_CFG_PARITY_EN
  logic par_err_reg;
  assign word_bad = (cfg_parity != ^cfg_data);
  assign par_err  = par_err_reg;
`else
  assign word_bad = 1'b0;
`endif

  assign accept   = cfg_valid && ready_reg;
  assign addr_oor = ({1'b0, cfg_addr} >= NUM_WL_L);

  // cfg_addr is 3 bits, so NUM_WL is at most 8; out-of-range or rejected words decode to all-zero
  generate
    for (genvar gi = 0; gi < NUM_WL; gi++) begin : g_dec
      assign sel_dec[gi] = (cfg_addr == 3'(gi)) && !word_bad;
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_bl
      assign bl_pat[gi] = cfg_data[gi];
    end
  endgenerate

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      last_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      addr_err_reg <= 1'b0;
      bl_reg       <= '0;
      wl_reg       <= '0;
      sel_reg      <= '0;
`ifdef IO_CFG_PARITY_EN
      par_err_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= SETUP;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            bl_reg    <= bl_pat;
            sel_reg   <= sel_dec;
            last_reg  <= cfg_last;
            if (addr_oor) addr_err_reg <= 1'b1;
`ifdef IO_CFG_PARITY_EN
            if (word_bad) par_err_reg <= 1'b1;
`endif
          end else begin
            ready_reg <= !done_reg;
          end
        end
        SETUP: begin
          state_reg <= PULSE;
          cnt_reg   <= '0;
          wl_reg    <= sel_reg;
        end
        PULSE: begin
          if (cnt_reg == PULSE_LAST) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            wl_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        HOLD: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          bl_reg    <= '0;
          if (last_reg) done_reg <= 1'b1;
          ready_reg <= !(done_reg || last_reg);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cfg_ready = ready_reg;
  assign bl        = bl_reg;
  assign wl        = wl_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign addr_err  = addr_err_reg;

endmodule

// File: tb/tb_io_cfg_bank_ctrl.sv
// Bench for io_cfg_bank_ctrl: two instances (8 wordlines / 2-cycle pulse, 6 wordlines / 3-cycle pulse)
// share random stimulus and are compared every cycle against a word-timeline reference model.
module tb_io_cfg_bank_ctrl;

  localparam int WP0 = 2;
  localparam int NW0 = 8;
  localparam int WP1 = 3;
  localparam int NW1 = 6;
`ifdef IO_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       prog_clk = 1'b0;
  logic       prog_rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_last = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
`ifdef IO_CFG_PARITY_EN
  logic       cfg_parity = 1'b0;
`endif

  logic       ready0, busy0, done0, aerr0, perr0;
  logic       ready1, busy1, done1, aerr1, perr1;
  logic [0:7] bl0, wl0, bl1, wl1x;
  logic [0:5] wl1;

  assign wl1x = {wl1, 2'b00};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: each word is a timeline of ages 1..WP+2 after its acceptance edge (0 = idle)
  int         m_age   [2];
  bit         m_ready [2];
  bit         m_done  [2];
  bit         m_aerr  [2];
  bit         m_perr  [2];
  bit         m_last  [2];
  bit         m_bad   [2];
  logic [2:0] m_addr  [2];
  logic [7:0] m_data  [2];
  logic [0:7] p_wl    [2];
  logic [0:7] p_bl    [2];

  always #5 prog_clk = ~prog_clk;

  io_cfg_bank_ctrl #(.WL_PULSE(WP0), .NUM_WL(NW0)) dut0 (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (ready0),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
`ifdef IO_CFG_PARITY_EN
    .cfg_parity (cfg_parity),
    .par_err    (perr0),
`endif
    .bl         (bl0),
    .wl         (wl0),
    .busy       (busy0),
    .done       (done0),
    .addr_err   (aerr0)
  );

  io_cfg_bank_ctrl #(.WL_PULSE(WP1), .NUM_WL(NW1)) dut1 (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (ready1),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
`ifdef IO_CFG_PARITY_EN
    .cfg_parity (cfg_parity),
    .par_err    (perr1),
`endif
    .bl         (bl1),
    .wl         (wl1),
    .busy       (busy1),
    .done       (done1),
    .addr_err   (aerr1)
  );

`ifndef IO_CFG_PARITY_EN
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic compare(input int k, input logic r, input logic b, input logic dn, input logic ae,
                         input logic pe, input logic [0:7] blv, input logic [0:7] wlv);
    logic [0:7] e_wl;
    logic [0:7] e_bl;
    logic [0:7] rising;
    int wpk;
    int nwk;
    wpk  = (k == 0) ? WP0 : WP1;
    nwk  = (k == 0) ? NW0 : NW1;
    e_wl = '0;
    e_bl = '0;
    if (m_age[k] > 0)
      for (int i = 0; i < 8; i++) e_bl[i] = m_data[k][i];
    if (m_age[k] >= 2 && m_age[k] <= wpk + 1 && int'(m_addr[k]) < nwk && !m_bad[k])
      e_wl[m_addr[k]] = 1'b1;
    check($sformatf("ready%0d", k), 32'(r), 32'(m_ready[k]));
    check($sformatf("busy%0d", k), 32'(b), 32'(m_age[k] > 0));
    check($sformatf("done%0d", k), 32'(dn), 32'(m_done[k]));
    check($sformatf("addr_err%0d", k), 32'(ae), 32'(m_aerr[k]));
    check($sformatf("bl%0d", k), 32'(blv), 32'(e_bl));
    check($sformatf("wl%0d", k), 32'(wlv), 32'(e_wl));
    check($sformatf("wl_onehot%0d", k), 32'($onehot0(wlv)), 32'd1);
`ifdef IO_CFG_PARITY_EN
    check($sformatf("par_err%0d", k), 32'(pe), 32'(m_perr[k]));
`else
    if (pe !== 1'b0) check($sformatf("par_tie%0d", k), 32'(pe), 32'd0);
`endif
    rising = wlv & ~p_wl[k];
    if (rising != '0) check($sformatf("bl_stable_at_wl_rise%0d", k), 32'(blv), 32'(p_bl[k]));
    p_wl[k] = wlv;
    p_bl[k] = blv;
  endtask

  task automatic model_edge(input int k, input bit rn, input bit v, input logic [2:0] a,
                            input logic [7:0] d, input bit l, input bit bad);
    int wpk;
    int nwk;
    wpk = (k == 0) ? WP0 : WP1;
    nwk = (k == 0) ? NW0 : NW1;
    if (!rn) begin
      m_age[k] = 0; m_ready[k] = 0; m_done[k] = 0; m_aerr[k] = 0; m_perr[k] = 0;
    end else if (m_age[k] == 0) begin
      if (v && m_ready[k]) begin
        m_age[k] = 1; m_ready[k] = 0;
        m_addr[k] = a; m_data[k] = d; m_last[k] = l; m_bad[k] = bad;
        if (int'(a) >= nwk) m_aerr[k] = 1;
        if (bad) m_perr[k] = 1;
        if (k == 0) $display("word cyc=%0d addr=%0d data=%02h last=%0d bad=%0d", cyc, a, d, l, bad);
      end else begin
        m_ready[k] = !m_done[k];
      end
    end else if (m_age[k] == wpk + 2) begin
      m_age[k] = 0;
      if (m_last[k]) m_done[k] = 1;
      m_ready[k] = !m_done[k];
    end else begin
      m_age[k]++;
    end
  endtask

  // Called at a falling edge: check current outputs, drive next inputs, advance model one edge
  task automatic step(input bit rn, input bit v, input logic [2:0] a, input logic [7:0] d,
                      input bit l, input bit pf);
    bit bad;
    compare(0, ready0, busy0, done0, aerr0, perr0, bl0, wl0);
    compare(1, ready1, busy1, done1, aerr1, perr1, bl1, wl1x);
    bad        = PAR_EN & pf;
    prog_rst_n = rn;
    cfg_valid  = v;
    cfg_addr   = a;
    cfg_data   = d;
    cfg_last   = l;
`ifdef IO_CFG_PARITY_EN
    cfg_parity = (^d) ^ pf;
`endif
    model_edge(0, rn, v, a, d, l, bad);
    model_edge(1, rn, v, a, d, l, bad);
    @(negedge prog_clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 3'($urandom), 8'($urandom), 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      model_edge(k, 0, 0, 0, 0, 0, 0);
      p_wl[k] = '0;
      p_bl[k] = '0;
    end
    @(negedge prog_clk);
    step(0, 0, 0, 0, 0, 0);

    // Single word addr=3, data=A5
    idle(1);
    step(1, 1, 3'd3, 8'hA5, 0, 0);
    idle(7);

    // Eight-word stream with valid held high, last on the eighth
    begin
      int w = 0;
      int guard = 0;
      while (w < 8 && guard < 200) begin
        step(1, 1, 3'(w), 8'($urandom), (w == 7), 0);
        if (m_age[0] == 1) w++;
        guard++;
      end
      check("stream_accept_count", 32'(w), 32'd8);
    end
    for (int i = 0; i < 12; i++) step(1, 1, 3'($urandom), 8'($urandom), 1'($urandom), 0);
    check("done_sticky", 32'(done0), 32'd1);
    check("ready_after_done", 32'(ready0), 32'd0);

    // addr 6 (out of range for the 6-wordline instance), then 7 followed by 0
    do_reset();
    idle(1);
    step(1, 1, 3'd6, 8'($urandom), 0, 0);
    idle(7);
    step(1, 1, 3'd7, 8'($urandom), 0, 0);
    idle(7);
    step(1, 1, 3'd0, 8'($urandom), 0, 0);
    idle(7);
    check("addr_err6_wl6", 32'(aerr1), 32'd1);

    // Reset on the first PULSE cycle
    do_reset();
    idle(1);
    step(1, 1, 3'd5, 8'($urandom), 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("wl_after_rst", 32'(wl0), 32'd0);
    idle(3);

    // Random traffic with occasional resets, last words and parity flips
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1), 3'($urandom), 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/io_cfg_bank_ctrl.md
IO_CFG_BANK_CTRL -- requirements
Module: io_cfg_bank_ctrl

Interface
REQ-001 Parameter WL_PULSE, default 2: wordline-high cycles per write, legal range 1..15.
REQ-002 Parameter NUM_WL, default 8: number of wordlines driven.
REQ-003 prog_clk  input  1  configuration clock; all state updates on its rising edge.
REQ-004 prog_rst_n  input  1  reset, synchronous, active-low.
REQ-005 cfg_valid  input  1  a configuration word is presented.
REQ-006 cfg_ready  output  1  the controller accepts the word this cycle.
REQ-007 cfg_addr  input  3  target wordline index, 0..NUM_WL-1.
REQ-008 cfg_data  input  8  bitline pattern, bit i drives bl[i].
REQ-009 cfg_last  input  1  marks the final word of a bitstream.
REQ-010 bl  output  [0:7]  bitline bus to the IO tile column.
REQ-011 wl  output  [0:NUM_WL-1]  wordline bus, one-hot or all-zero.
REQ-012 busy  output  1  a write sequence is in progress.
REQ-013 done  output  1  sticky flag: the last word has been written.
REQ-014 addr_err  output  1  sticky flag: a word with cfg_addr >= NUM_WL was received.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETUP, PULSE, HOLD.
REQ-016 IDLE: cfg_ready=1; on cfg_valid&&cfg_ready, capture addr, data and last, then go to SETUP.
REQ-017 cfg_ready SHALL be 1 only in IDLE; there is no back-to-back acceptance.
REQ-018 SETUP, 1 cycle: bl is driven with the captured data, wl=0; next state PULSE.
REQ-019 PULSE, WL_PULSE cycles exactly: wl[addr]=1, all other wl=0, bl held; a 4-bit counter counts the cycles; after the last cycle go to HOLD.
REQ-020 HOLD, 1 cycle: wl=0, bl still held; next state IDLE, where bl is driven to 0.
REQ-021 Throughput SHALL be one word per WL_PULSE+3 cycles (accept, SETUP, PULSE, HOLD).
REQ-022 busy SHALL be 1 in SETUP, PULSE and HOLD.
REQ-023 An out-of-range addr (>=NUM_WL) SHALL be accepted and run the full SETUP/PULSE/HOLD timing with wl kept at all-zero; addr_err is set on the cycle after acceptance.
REQ-024 done SHALL set on exit from HOLD of a word captured with cfg_last=1.
REQ-025 While done=1, cfg_ready=0 and the FSM stays in IDLE until reset.
REQ-026 wl SHALL never have more than one bit set, and no wl bit SHALL rise in the same cycle that bl changes.
REQ-027 cfg_valid deasserting without a handshake has no effect; inputs are sampled only at the handshake.

Reset
REQ-028 While prog_rst_n=0 at a clock edge, the block SHALL enter IDLE with bl=0, wl=0, busy=0, done=0, addr_err=0, the pulse counter at 0, and cfg_ready=0 during that cycle.
REQ-029 A reset asserted in any state, including mid-PULSE, SHALL drop wl to 0 on the next edge and abort the word; no partial recovery is attempted.
REQ-030 cfg_ready SHALL return to 1 on the first cycle after prog_rst_n is sampled high.

Configuration
REQ-031 Macro IO_CFG_PARITY_EN defined: an extra input cfg_parity (1 bit, even parity over cfg_data) is added; a mismatch at the handshake sets sticky output par_err and the word runs with wl forced to all-zero.
REQ-032 Macro IO_CFG_PARITY_EN undefined: neither the cfg_parity port nor par_err exists, and no check is made.

Verification
REQ-033 Reset, then one word addr=3, data=8'hA5, WL_PULSE=2 -> bl=A5 in SETUP; wl=8'b00010000 (wl[3]) for exactly 2 cycles; wl=0 in HOLD; ready again 5 cycles after the handshake.
REQ-034 Stream of 8 words, addr 0..7, with cfg_valid held high and cfg_last on the 8th -> each wl bit pulses once in order; done=1 after the 8th HOLD; cfg_ready stays 0 afterward.
REQ-035 A word with addr=7 followed by a word with addr=0 -> wl is never multi-hot; bl changes only when wl=0.
REQ-036 prog_rst_n pulled low on the 1st PULSE cycle -> wl=0 on the next edge, and all flags and outputs at reset values.
REQ-037 With NUM_WL=6, addr=6 -> wl stays 0 throughout, addr_err=1, and timing is unchanged.
REQ-038 With IO_CFG_PARITY_EN, data=8'h01 and cfg_parity=0 -> par_err=1 and wl stays 0; with cfg_parity=1 -> normal pulse and par_err=0.
